// File: rtl/probe_trace_reader.sv
// Trigger-armed capture of a probe vector into a DEPTH-entry trace buffer,
// streamed back out over a valid/ready read port, oldest sample first.
module probe_trace_reader #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    input  logic [WIDTH-1:0] probe_in,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic             busy,
    output logic             triggered,
    output logic [AW:0]      count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_READOUT
    } state_t;

    localparam logic [AW:0]   LP_CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] LP_PTR_LAST = AW'(DEPTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_trig;
    logic             r_busy;
    logic             r_rd_valid;
    logic             r_rd_last;
    logic [WIDTH-1:0] r_rd_data;

    logic             w_hit;
    logic             w_we;
    logic             w_xfer;
    logic [AW-1:0]    w_rnext;

    assign w_hit   = ((probe_in ^ trig_value) & trig_mask) == '0;
    assign w_we    = !abort && ((r_state == S_ARMED && w_hit) ||
                                 r_state == S_CAPTURE);
    assign w_xfer  = r_rd_valid && rd_ready;
    assign w_rnext = r_rptr + 1'b1;

    // Trace storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_buf[r_wptr] <= probe_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_trig     <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
        end else if (abort) begin
            r_state    <= S_IDLE;
            r_trig     <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state <= S_ARMED;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_trig  <= 1'b0;
                        r_wptr  <= '0;
                        r_rptr  <= '0;
                    end
                end
                S_ARMED: begin
                    if (w_hit) begin
                        r_state <= S_CAPTURE;
                        r_wptr  <= r_wptr + 1'b1;
                        r_count <= (AW+1)'(1);
                        r_trig  <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_wptr  <= r_wptr + 1'b1;
                    r_count <= r_count + 1'b1;
                    // The oldest entry was written long ago, so no bypass.
                    if (r_count == LP_CNT_LAST) begin
                        r_state    <= S_READOUT;
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= r_buf[r_rptr];
                        r_rd_last  <= (r_rptr == LP_PTR_LAST);
                    end
                end
                S_READOUT: begin
                    if (w_xfer) begin
                        r_rptr <= w_rnext;
                        if (r_rd_last) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_rd_valid <= 1'b0;
                            r_rd_last  <= 1'b0;
                            r_rd_data  <= '0;
                        end else begin
                            r_rd_data <= r_buf[w_rnext];
                            r_rd_last <= (w_rnext == LP_PTR_LAST);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_last   = r_rd_last;
    assign busy      = r_busy;
    assign triggered = r_trig;
    assign count     = r_count;

endmodule

// File: tb/tb_probe_trace_reader.sv
// Bench for probe_trace_reader: trigger table, trace sequences checked
// against a stream-level model, abort and async-reset corner cases.
module tb_probe_trace_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] trig_mask = '0;
    logic [2:0] trig_value = '0;
    logic [2:0] probe_in = '0;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [2:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic       triggered;
    logic [3:0] count;

    int total = 0;
    int bad = 0;

    probe_trace_reader #(.WIDTH(3), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_value(trig_value),
        .probe_in(probe_in), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
        .triggered(triggered), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] m;
        logic [2:0] v;
        logic [2:0] p;
        logic       hit;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one full arm/trigger/capture/readout and compare the
    // transferred stream with the probe history from the trigger onward.
    task automatic do_trace(input logic [2:0] m, input logic [2:0] v,
                            input logic [2:0] arm_p, input int pmode,
                            input int start, input int rmode,
                            input bit arm_ro);
        logic [2:0] hist [$];
        logic [2:0] got_d [$];
        logic       got_l [$];
        logic [2:0] p;
        logic [2:0] pd;
        logic       pl;
        bit         pstall;
        int         first_v;
        int         t;
        int         i;
        pstall = 0;
        first_v = -1;
        t = -1;
        i = 0;
        pd = '0;
        pl = 1'b0;
        trig_mask = m;
        trig_value = v;
        probe_in = arm_p;
        rd_ready = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        while (got_d.size() < 8 && i < 400) begin
            case (pmode)
                0: p = 3'(start + i);
                1: p = 3'b010;
                default: p = 3'($urandom_range(0, 7));
            endcase
            probe_in = p;
            hist.push_back(p);
            case (rmode)
                0: rd_ready = 1'b1;
                1: rd_ready = (i % 3 == 0);
                default: rd_ready = 1'($urandom % 2);
            endcase
            arm = 1'b0;
            if (rd_valid && first_v < 0) begin
                first_v = i;
                arm = arm_ro;
            end
            if (pstall) begin
                chk("stall_valid", 32'(rd_valid), 1);
                chk("stall_data", 32'(rd_data), 32'(pd));
                chk("stall_last", 32'(rd_last), 32'(pl));
            end
            pstall = rd_valid && !rd_ready;
            pd = rd_data;
            pl = rd_last;
            if (rd_valid && rd_ready) begin
                got_d.push_back(rd_data);
                got_l.push_back(rd_last);
            end
            step();
            i++;
        end
        arm = 1'b0;
        rd_ready = 1'b0;
        chk("xfers", 32'(got_d.size()), 8);
        for (int k = 0; k < hist.size(); k++) begin
            if (((hist[k] ^ v) & m) == 3'b000) begin
                t = k;
                break;
            end
        end
        chk("trig_found", 32'(t >= 0 && t + 8 <= hist.size()), 1);
        if (t >= 0) begin
            for (int k = 0; k < got_d.size(); k++) begin
                if (t + k < hist.size())
                    chk("rd_data", 32'(got_d[k]), 32'(hist[t+k]));
                chk("rd_last", 32'(got_l[k]), 32'(k == 7));
            end
            chk("first_valid", 32'(first_v), 32'(t + 8));
        end
        chk("end_valid", 32'(rd_valid), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_count", 32'(count), 8);
        chk("end_trig", 32'(triggered), 1);
    endtask

    initial begin
        int n;
        bit seen;
        tbl[0] = '{3'b111, 3'b101, 3'b101, 1'b1};
        tbl[1] = '{3'b111, 3'b101, 3'b100, 1'b0};
        tbl[2] = '{3'b000, 3'b110, 3'b001, 1'b1};
        tbl[3] = '{3'b100, 3'b100, 3'b111, 1'b1};
        tbl[4] = '{3'b100, 3'b100, 3'b011, 1'b0};
        tbl[5] = '{3'b011, 3'b001, 3'b101, 1'b1};
        tbl[6] = '{3'b011, 3'b001, 3'b110, 1'b0};
        tbl[7] = '{3'b010, 3'b000, 3'b101, 1'b1};

        repeat (2) step();
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_last", 32'(rd_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_trig", 32'(triggered), 0);
        chk("rst_count", 32'(count), 0);
        rst = 1'b0;
        step();

        foreach (tbl[k]) begin
            trig_mask = tbl[k].m;
            trig_value = tbl[k].v;
            arm = 1'b1;
            step();
            arm = 1'b0;
            probe_in = tbl[k].p;
            step();
            chk("tbl_trig", 32'(triggered), 32'(tbl[k].hit));
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("tbl_abort_busy", 32'(busy), 0);
        end

        do_trace(3'b111, 3'b101, 3'b000, 0, 0, 0, 1'b0);
        do_trace(3'b000, 3'b000, 3'b010, 1, 0, 0, 1'b0);
        do_trace(3'b000, 3'b000, 3'b010, 2, 0, 1, 1'b0);
        do_trace(3'b111, 3'b101, 3'b101, 0, 6, 0, 1'b1);
        do_trace(3'b111, 3'b011, 3'b000, 0, 1, 1, 1'b1);
        for (int r = 0; r < 6; r++) begin
            do_trace(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 2, 0, 2, 1'($urandom % 2));
        end

        trig_mask = 3'b000;
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (4) step();
        chk("ab_count_pre", 32'(count), 4);
        chk("ab_busy_pre", 32'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_trig", 32'(triggered), 0);
        chk("ab_count", 32'(count), 4);
        seen = 0;
        repeat (10) begin
            step();
            if (rd_valid) seen = 1;
        end
        chk("ab_no_valid", 32'(seen), 0);
        trig_mask = 3'b111;
        trig_value = 3'b111;
        probe_in = 3'b000;
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("rearm_count", 32'(count), 0);
        chk("rearm_busy", 32'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        trig_mask = 3'b000;
        rd_ready = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        n = 0;
        while (!rd_valid && n < 50) begin
            step();
            n++;
        end
        chk("ar_valid_pre", 32'(rd_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(rd_valid), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_trig", 32'(triggered), 0);
        chk("ar_count", 32'(count), 0);
        #1 rst = 1'b0;
        repeat (3) step();
        chk("ar_idle_busy", 32'(busy), 0);
        chk("ar_idle_valid", 32'(rd_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
